// File: rtl/riscv_defs.sv
// Shared definitions for the core: FSM state encodings, decode-net bit indices
// and small helpers for grouping instructions by class.
package riscv_defs;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned DECODE_W = 37;
  localparam int unsigned OP_W     = 6;

  // Core FSM state encodings.
  localparam logic [STATE_W-1:0] FETCH     = 3'd0;
  localparam logic [STATE_W-1:0] DECODE    = 3'd1;
  localparam logic [STATE_W-1:0] EXECUTE_1 = 3'd2;
  localparam logic [STATE_W-1:0] EXECUTE_2 = 3'd3;
  localparam logic [STATE_W-1:0] MEMORY    = 3'd4;
  localparam logic [STATE_W-1:0] WRITEBACK = 3'd5;

  // Bit positions in the one-hot decode net.
  localparam logic [OP_W-1:0] IS_LUI   = 6'd0;
  localparam logic [OP_W-1:0] IS_AUIPC = 6'd1;
  localparam logic [OP_W-1:0] IS_JAL   = 6'd2;
  localparam logic [OP_W-1:0] IS_JALR  = 6'd3;
  localparam logic [OP_W-1:0] IS_BEQ   = 6'd4;
  localparam logic [OP_W-1:0] IS_BNE   = 6'd5;
  localparam logic [OP_W-1:0] IS_BLT   = 6'd6;
  localparam logic [OP_W-1:0] IS_BGE   = 6'd7;
  localparam logic [OP_W-1:0] IS_BLTU  = 6'd8;
  localparam logic [OP_W-1:0] IS_BGEU  = 6'd9;
  localparam logic [OP_W-1:0] IS_LB    = 6'd10;
  localparam logic [OP_W-1:0] IS_LH    = 6'd11;
  localparam logic [OP_W-1:0] IS_LW    = 6'd12;
  localparam logic [OP_W-1:0] IS_LBU   = 6'd13;
  localparam logic [OP_W-1:0] IS_LHU   = 6'd14;
  localparam logic [OP_W-1:0] IS_SB    = 6'd15;
  localparam logic [OP_W-1:0] IS_SH    = 6'd16;
  localparam logic [OP_W-1:0] IS_SW    = 6'd17;
  localparam logic [OP_W-1:0] IS_ADDI  = 6'd18;
  localparam logic [OP_W-1:0] IS_SLTI  = 6'd19;
  localparam logic [OP_W-1:0] IS_SLTIU = 6'd20;
  localparam logic [OP_W-1:0] IS_XORI  = 6'd21;
  localparam logic [OP_W-1:0] IS_ORI   = 6'd22;
  localparam logic [OP_W-1:0] IS_ANDI  = 6'd23;
  localparam logic [OP_W-1:0] IS_SLLI  = 6'd24;
  localparam logic [OP_W-1:0] IS_SRLI  = 6'd25;
  localparam logic [OP_W-1:0] IS_SRAI  = 6'd26;
  localparam logic [OP_W-1:0] IS_ADD   = 6'd27;
  localparam logic [OP_W-1:0] IS_SUB   = 6'd28;
  localparam logic [OP_W-1:0] IS_SLL   = 6'd29;
  localparam logic [OP_W-1:0] IS_SLT   = 6'd30;
  localparam logic [OP_W-1:0] IS_SLTU  = 6'd31;
  localparam logic [OP_W-1:0] IS_XOR   = 6'd32;
  localparam logic [OP_W-1:0] IS_SRL   = 6'd33;
  localparam logic [OP_W-1:0] IS_SRA   = 6'd34;
  localparam logic [OP_W-1:0] IS_OR    = 6'd35;
  localparam logic [OP_W-1:0] IS_AND   = 6'd36;

  function automatic logic is_branch(logic [OP_W-1:0] op);
    return (op >= IS_BEQ) && (op <= IS_BGEU);
  endfunction

  function automatic logic is_mem(logic [OP_W-1:0] op);
    return (op >= IS_LB) && (op <= IS_SW);
  endfunction

  // Register-immediate ALU ops take their second operand from imm.
  function automatic logic is_alu_imm(logic [OP_W-1:0] op);
    return (op >= IS_ADDI) && (op <= IS_SRAI);
  endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU and branch comparator for the execute stage.
// op_i is the index of the selected decode bit; b_i is already muxed to
// rs2 or imm by the caller.
module execute_alu
  import riscv_defs::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [31:0]     a_i,
  input  logic [31:0]     b_i,
  output logic [31:0]     result_o,
  output logic            taken_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // ALU result for register-register and register-immediate ops.
  always_comb begin
    result_o = '0;
    case (op_i)
      IS_ADDI, IS_ADD:   result_o = a_i + b_i;
      IS_SUB:            result_o = a_i - b_i;
      IS_SLTI, IS_SLT:   result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      IS_SLTIU, IS_SLTU: result_o = {31'b0, a_i < b_i};
      IS_XORI, IS_XOR:   result_o = a_i ^ b_i;
      IS_ORI, IS_OR:     result_o = a_i | b_i;
      IS_ANDI, IS_AND:   result_o = a_i & b_i;
      IS_SLLI, IS_SLL:   result_o = a_i << shamt;
      IS_SRLI, IS_SRL:   result_o = a_i >> shamt;
      IS_SRAI, IS_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      default:           result_o = '0;
    endcase
  end

  // Branch condition evaluation.
  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      IS_BEQ:  taken_o = (a_i == b_i);
      IS_BNE:  taken_o = (a_i != b_i);
      IS_BLT:  taken_o = ($signed(a_i) < $signed(b_i));
      IS_BGE:  taken_o = ($signed(a_i) >= $signed(b_i));
      IS_BLTU: taken_o = (a_i < b_i);
      IS_BGEU: taken_o = (a_i >= b_i);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: computes rd value, branch/jump target or memory address and
// the redirect flag, registered when the core is in EXECUTE_1.
// Optional macro EXECUTE_ONEHOT_CHECK_EN enables a simulation check that the
// decode net is one-hot while executing.
module execute_unit
  import riscv_defs::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [STATE_W-1:0]  state_i,
  input  logic [31:0]         rs1_val_i,
  input  logic [31:0]         rs2_val_i,
  input  logic [31:0]         imm_i,
  input  logic [31:0]         pc_i,
  input  logic [DECODE_W-1:0] decode_net_i,
  output logic [31:0]         writeback_value_o,
  output logic [31:0]         address_o,
  output logic                branch_taken_o
);

  logic [OP_W-1:0] op_idx;
  logic            op_valid;
  logic [31:0]     alu_b;
  logic [31:0]     alu_result;
  logic            alu_taken;

  logic [31:0] wb_d, wb_q;
  logic [31:0] addr_d, addr_q;
  logic        taken_d, taken_q;

  // Priority encode the decode net; the lowest set bit wins.
  always_comb begin
    op_valid = 1'b0;
    op_idx   = '0;
    for (int i = DECODE_W - 1; i >= 0; i--) begin
      if (decode_net_i[i]) begin
        op_valid = 1'b1;
        op_idx   = OP_W'(i);
      end
    end
  end

  // rs2 is only routed to the ALU when the op actually needs it.
  assign alu_b = is_alu_imm(op_idx) ? imm_i : rs2_val_i;

  execute_alu u_alu (
    .op_i     (op_idx),
    .a_i      (rs1_val_i),
    .b_i      (alu_b),
    .result_o (alu_result),
    .taken_o  (alu_taken)
  );

  // Select results per instruction class; unused operands never reach outputs.
  always_comb begin
    wb_d    = '0;
    addr_d  = '0;
    taken_d = 1'b0;
    if (op_valid) begin
      if (op_idx == IS_LUI) begin
        wb_d = imm_i;
      end else if (op_idx == IS_AUIPC) begin
        wb_d = pc_i + imm_i;
      end else if (op_idx == IS_JAL) begin
        wb_d    = pc_i + 32'd4;
        addr_d  = pc_i + imm_i;
        taken_d = 1'b1;
      end else if (op_idx == IS_JALR) begin
        wb_d    = pc_i + 32'd4;
        addr_d  = (rs1_val_i + imm_i) & 32'hFFFF_FFFE;
        taken_d = 1'b1;
      end else if (is_branch(op_idx)) begin
        addr_d  = pc_i + imm_i;
        taken_d = alu_taken;
      end else if (is_mem(op_idx)) begin
        addr_d = rs1_val_i + imm_i;
      end else begin
        wb_d = alu_result;
      end
    end
  end

  // Output registers: reset wins, update only in EXECUTE_1, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_q    <= '0;
      addr_q  <= '0;
      taken_q <= 1'b0;
    end else if (state_i == EXECUTE_1) begin
      wb_q    <= wb_d;
      addr_q  <= addr_d;
      taken_q <= taken_d;
    end
  end

  assign writeback_value_o = wb_q;
  assign address_o         = addr_q;
  assign branch_taken_o    = taken_q;

`ifdef EXECUTE_ONEHOT_CHECK_EN
  // Catch decoder bugs that the lowest-bit priority pick would otherwise hide.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_i == EXECUTE_1) begin
      assert ($countones(decode_net_i) <= 1)
      else $error("execute_unit: decode_net_i not one-hot: %h", decode_net_i);
    end
  end
`endif

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed cases plus random stimulus
// checked against an instruction-level reference model.
module tb_execute_unit;
  import riscv_defs::*;

  logic                clk;
  logic                rst;
  logic [STATE_W-1:0]  state;
  logic [31:0]         rs1, rs2, imm, pc;
  logic [DECODE_W-1:0] dec;
  logic [31:0]         wb_o, addr_o;
  logic                taken_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_wb, exp_addr;
  logic        exp_taken;

  execute_unit dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .state_i           (state),
    .rs1_val_i         (rs1),
    .rs2_val_i         (rs2),
    .imm_i             (imm),
    .pc_i              (pc),
    .decode_net_i      (dec),
    .writeback_value_o (wb_o),
    .address_o         (addr_o),
    .branch_taken_o    (taken_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DECODE_W-1:0] oh(int i);
    logic [DECODE_W-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference model: returns {taken, addr, wb} for one instruction.
  function automatic logic [64:0] ref_exec(logic [DECODE_W-1:0] d, logic [31:0] a,
                                           logic [31:0] b, logic [31:0] im,
                                           logic [31:0] p);
    logic [31:0] w, ad;
    logic        t;
    int          k;
    w = 0; ad = 0; t = 0; k = -1;
    for (int i = 0; i < DECODE_W; i++) if (d[i] && k < 0) k = i;
    case (k)
      0:  w = im;                                       // LUI
      1:  w = p + im;                                   // AUIPC
      2:  begin w = p + 4; ad = p + im; t = 1; end      // JAL
      3:  begin w = p + 4; ad = (a + im) & ~32'd1; t = 1; end
      4:  begin ad = p + im; t = (a == b); end
      5:  begin ad = p + im; t = (a != b); end
      6:  begin ad = p + im; t = ($signed(a) < $signed(b)); end
      7:  begin ad = p + im; t = !($signed(a) < $signed(b)); end
      8:  begin ad = p + im; t = (a < b); end
      9:  begin ad = p + im; t = !(a < b); end
      10, 11, 12, 13, 14, 15, 16, 17: ad = a + im;
      18: w = a + im;
      19: w = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
      20: w = (a < im) ? 32'd1 : 32'd0;
      21: w = a ^ im;
      22: w = a | im;
      23: w = a & im;
      24: w = a << im[4:0];
      25: w = a >> im[4:0];
      26: w = $unsigned($signed(a) >>> im[4:0]);
      27: w = a + b;
      28: w = a - b;
      29: w = a << b[4:0];
      30: w = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      31: w = (a < b) ? 32'd1 : 32'd0;
      32: w = a ^ b;
      33: w = a >> b[4:0];
      34: w = $unsigned($signed(a) >>> b[4:0]);
      35: w = a | b;
      36: w = a & b;
      default: ;
    endcase
    return {t, ad, w};
  endfunction

  // Drive one cycle, update the expected registers, then compare.
  task automatic step(input string tag, input logic r, input logic [STATE_W-1:0] st,
                      input logic [DECODE_W-1:0] d, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im, input logic [31:0] p);
    logic [64:0] res;
    @(negedge clk);
    rst = r; state = st; dec = d; rs1 = a; rs2 = b; imm = im; pc = p;
    res = ref_exec(d, a, b, im, p);
    if (r) begin
      exp_wb = 0; exp_addr = 0; exp_taken = 0;
    end else if (st == EXECUTE_1) begin
      exp_wb = res[31:0]; exp_addr = res[63:32]; exp_taken = res[64];
    end
    @(posedge clk);
    #1;
    checks++;
    assert (wb_o === exp_wb)
    else begin errors++; $error("FAIL %s wb got %h exp %h", tag, wb_o, exp_wb); end
    checks++;
    assert (addr_o === exp_addr)
    else begin errors++; $error("FAIL %s addr got %h exp %h", tag, addr_o, exp_addr); end
    checks++;
    assert (taken_o === exp_taken)
    else begin errors++; $error("FAIL %s taken got %b exp %b", tag, taken_o, exp_taken); end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [DECODE_W-1:0] d;
    logic [STATE_W-1:0]  st;
    logic [63:0]         mask;
    rst = 1; state = FETCH; dec = '0; rs1 = 0; rs2 = 0; imm = 0; pc = 0;
    exp_wb = 0; exp_addr = 0; exp_taken = 0;

    step("reset", 1, FETCH, '0, 0, 0, 0, 0);
    step("reset_exec", 1, EXECUTE_1, oh(IS_JAL), 0, 0, 4, 0);

    // Directed cases from the functional rules.
    step("addi", 0, EXECUTE_1, oh(IS_ADDI), 1, 0, 4, 0);
    step("sub", 0, EXECUTE_1, oh(IS_SUB), 1, 3, 0, 0);
    step("sra", 0, EXECUTE_1, oh(IS_SRA), 32'h8000_0000, 1, 0, 0);
    step("slt", 0, EXECUTE_1, oh(IS_SLT), 32'hFFFF_FFFF, 2, 0, 0);
    step("sltu", 0, EXECUTE_1, oh(IS_SLTU), 2, 32'hFFFF_FFFF, 0, 0);
    step("sltiu", 0, EXECUTE_1, oh(IS_SLTIU), 32'hFFFF_FFFF, 0, 2, 0);
    step("beq", 0, EXECUTE_1, oh(IS_BEQ), 1, 1, 4, 0);
    step("bge", 0, EXECUTE_1, oh(IS_BGE), 32'hFFFF_FFFF, 0, 4, 0);
    step("bgeu", 0, EXECUTE_1, oh(IS_BGEU), 32'hFFFF_FFFF, 0, 4, 0);
    step("bltu", 0, EXECUTE_1, oh(IS_BLTU), 32'hFFFF_FFFF, 2, 4, 0);
    step("jal", 0, EXECUTE_1, oh(IS_JAL), 0, 0, 4, 0);
    step("jalr", 0, EXECUTE_1, oh(IS_JALR), 8, 0, 4, 0);
    step("jalr_odd", 0, EXECUTE_1, oh(IS_JALR), 7, 0, 0, 0);
    step("lw", 0, EXECUTE_1, oh(IS_LW), 1, 0, 4, 0);
    step("sb", 0, EXECUTE_1, oh(IS_SB), 1, 32'h1234, 4, 0);
    step("auipc", 0, EXECUTE_1, oh(IS_AUIPC), 0, 0, 4, 32'h100);
    step("lui", 0, EXECUTE_1, oh(IS_LUI), 0, 0, 10, 0);

    // Unused operands carrying X must not leak into outputs.
    step("addi_x", 0, EXECUTE_1, oh(IS_ADDI), 1, 'x, 4, 0);
    step("lui_x", 0, EXECUTE_1, oh(IS_LUI), 'x, 'x, 10, 0);
    step("jal_x", 0, EXECUTE_1, oh(IS_JAL), 'x, 'x, 8, 32'h40);
    step("lw_x", 0, EXECUTE_1, oh(IS_LW), 3, 'x, 5, 0);

    // Hold outside EXECUTE_1, zero decode, priority and reset.
    step("jal_pre", 0, EXECUTE_1, oh(IS_JAL), 0, 0, 4, 0);
    step("hold", 0, DECODE, oh(IS_ADD), 5, 6, 7, 8);
    step("hold2", 0, EXECUTE_2, oh(IS_LUI), 0, 0, 99, 0);
    step("zero_dec", 0, EXECUTE_1, '0, 5, 6, 7, 8);
    step("prio", 0, EXECUTE_1, oh(IS_ADD) | oh(IS_SUB) | oh(IS_AND), 5, 3, 0, 0);
    step("jal_pre2", 0, EXECUTE_1, oh(IS_JAL), 0, 0, 4, 0);
    step("rst_exec", 1, EXECUTE_1, oh(IS_JAL), 0, 0, 4, 0);
    step("post_rst", 0, EXECUTE_1, oh(IS_ADDI), 1, 0, 4, 0);

    // Random instructions, states and operands.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: d = '0;
        1, 2: begin
          mask = {$urandom, $urandom};
          d = oh($urandom_range(0, DECODE_W - 1)) | mask[DECODE_W-1:0];
        end
        default: d = oh($urandom_range(0, DECODE_W - 1));
      endcase
      st = ($urandom_range(0, 1) == 0) ? EXECUTE_1 : STATE_W'($urandom_range(0, 7));
      step("rand", ($urandom_range(0, 49) == 0), st, d, rnd32(), rnd32(), rnd32(), rnd32());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_i input 1 (rising-edge clock); rst_i input 1 (synchronous active-high reset).
REQ-002 SHALL have ports:
- state_i input 3: core FSM state.
- rs1_val_i input 32: rs1 operand.
- rs2_val_i input 32: rs2 operand.
- imm_i input 32: sign-extended immediate (LUI/AUIPC: already shifted, upper form).
- pc_i input 32: PC of the current instruction.
- decode_net_i input 37: one-hot instruction flags, bit index = IS_* constant.
- writeback_value_o output 32: rd result.
- address_o output 32: branch/jump target or load/store effective address.
- branch_taken_o output 1: redirect PC to address_o.
REQ-003 SHALL have no parameters; all constants come from the shared package.

Function
REQ-004 SHALL register all outputs on the rising clk_i edge when state_i == EXECUTE_1; one-cycle latency; outputs hold in any other state.
REQ-005 SHALL use a fixed one-hot index order, 0..36: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-006 SHALL compute results for ALU ops into wb, with addr=0 and taken=0. Op (a=rs1, b=rs2 or imm for the I-forms):
- ADD, SUB, AND, OR, XOR: as named.
- SLL, SRL, SRA: shift amount = b[4:0]; SRA is arithmetic.
- SLT, SLTI: signed compare, result 1/0.
- SLTU, SLTIU: unsigned compare, result 1/0.
- All arithmetic is mod 2^32.
REQ-007 SHALL handle upper-immediate ops: LUI wb=imm; AUIPC wb=pc+imm; addr=0; taken=0.
REQ-008 SHALL handle branches: wb=0; addr=pc+imm; taken per compare: BEQ ==, BNE !=, BLT/BGE signed, BLTU/BGEU unsigned.
REQ-009 SHALL handle loads and stores (all widths): addr=rs1+imm; wb=0; taken=0. Memory access is done outside this block.
REQ-010 SHALL handle JAL: wb=pc+4, addr=pc+imm, taken=1.
REQ-011 SHALL handle JALR: wb=pc+4, addr=(rs1+imm)&~1, taken=1.
REQ-012 SHALL, when decode_net_i==0 in EXECUTE_1, register wb=0, addr=0, taken=0.
REQ-013 SHALL, if more than one decode bit is set, let the lowest-index set bit determine all outputs.
REQ-014 SHALL keep rs2_val_i irrelevant for I-type/U/J/load ops, and rs1_val_i irrelevant for LUI/AUIPC/JAL; X on an unused operand SHALL NOT propagate to outputs.

Reset
REQ-015 SHALL, when rst_i=1 at a rising edge, clear writeback_value_o, address_o and branch_taken_o to 0, regardless of state_i.
REQ-016 SHALL give reset priority over an EXECUTE_1 update in the same cycle; the first update after reset deasserts follows REQ-004.

Configuration
REQ-017 SHALL support macro EXECUTE_ONEHOT_CHECK_EN:
- Defined: a simulation-only check reports an error whenever state_i==EXECUTE_1 and decode_net_i has more than one bit set.
- Undefined: no check logic; functional behaviour identical.

Structure
REQ-018 SHALL take from the shared package riscv_defs: state encodings (EXECUTE_1 etc.), the IS_* bit indices, and the decode width 37.
REQ-019 SHALL use one natural sub-module, execute_alu: combinational, computing ALU results and branch compares. Output registering SHALL stay in execute.

Verification
REQ-020 ADDI rs1=1 imm=4 -> wb=5, addr=0, taken=0; SUB rs1=1 rs2=3 -> wb=0xFFFFFFFE.
REQ-021 Shift and compare ops:
- SRA rs1=0x80000000 rs2=1 -> 0xC0000000.
- SLT rs1=0xFFFFFFFF rs2=2 -> 1.
- SLTU rs1=2 rs2=0xFFFFFFFF -> 1.
- SLTIU rs1=0xFFFFFFFF imm=2 -> 0.
REQ-022 Branches, pc=0:
- BEQ 1,1 imm=4 -> addr=4, taken=1.
- BGE 0xFFFFFFFF,0 -> taken=0.
- BGEU same operands -> taken=1.
- BLTU 0xFFFFFFFF,2 -> taken=0.
REQ-023 Jumps and memory ops, pc=0:
- JAL imm=4 -> wb=4, addr=4, taken=1.
- JALR rs1=8 imm=4 -> wb=4, addr=12, taken=1.
- JALR rs1=7 imm=0 -> addr=6.
- LW/SB rs1=1 imm=4 -> addr=5, wb=0.
REQ-024 AUIPC pc=0x100 imm=4 -> wb=0x104; LUI imm=10 -> wb=10.
REQ-025 Hold and reset behaviour:
- Outputs hold when state_i != EXECUTE_1.
- decode_net_i=0 -> all outputs 0.
- rst_i during EXECUTE_1 -> all outputs 0 next edge.
